// File: rtl/alu_control_mc_pkg.sv
// Shared definitions for the multi-cycle ALU control decoder: ALU op codes,
// alu_op class encodings, MIPS funct codes and the decode helper.
package alu_control_mc_pkg;

  // Width of the shared ALU op code.
  localparam int unsigned ALU_CTRL_WIDTH = 4;

  // ALU op codes. Code 0 is a no-op; it marks illegal decodes and reset.
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_NOP   = 4'd0;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD   = 4'd1;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB   = 4'd2;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND   = 4'd3;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR    = 4'd4;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_XOR   = 4'd5;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_NOR   = 4'd6;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLT   = 4'd7;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLTU  = 4'd8;
  // Variable shifts reuse these; the shift-amount source is chosen in the datapath.
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLL   = 4'd9;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRL   = 4'd10;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRA   = 4'd11;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_MULT  = 4'd12;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_MULTU = 4'd13;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_DIV   = 4'd14;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_DIVU  = 4'd15;

  // alu_op class encodings driven by the main controller.
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_OR    = 3'b100;
  localparam logic [2:0] ALUOP_XOR   = 3'b101;
  localparam logic [2:0] ALUOP_SLT   = 3'b110;
  localparam logic [2:0] ALUOP_SLTU  = 3'b111;

  // MIPS R-type funct field values.
  localparam logic [5:0] FUNCT_SLL   = 6'h00;
  localparam logic [5:0] FUNCT_SRL   = 6'h02;
  localparam logic [5:0] FUNCT_SRA   = 6'h03;
  localparam logic [5:0] FUNCT_SLLV  = 6'h04;
  localparam logic [5:0] FUNCT_SRLV  = 6'h06;
  localparam logic [5:0] FUNCT_SRAV  = 6'h07;
  localparam logic [5:0] FUNCT_JR    = 6'h08;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
  localparam logic [5:0] FUNCT_ADD   = 6'h20;
  localparam logic [5:0] FUNCT_ADDU  = 6'h21;
  localparam logic [5:0] FUNCT_SUB   = 6'h22;
  localparam logic [5:0] FUNCT_SUBU  = 6'h23;
  localparam logic [5:0] FUNCT_AND   = 6'h24;
  localparam logic [5:0] FUNCT_OR    = 6'h25;
  localparam logic [5:0] FUNCT_XOR   = 6'h26;
  localparam logic [5:0] FUNCT_NOR   = 6'h27;
  localparam logic [5:0] FUNCT_SLT   = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU  = 6'h2B;

  // HI/LO read select.
  localparam logic [1:0] HILO_RD_NONE = 2'b00;
  localparam logic [1:0] HILO_RD_LO   = 2'b01;
  localparam logic [1:0] HILO_RD_HI   = 2'b10;

  // One decoded request; this is exactly what the output register holds.
  typedef struct packed {
    logic [ALU_CTRL_WIDTH-1:0] ctrl;
    logic                      hilo_we;
    logic [1:0]                hilo_rd;
    logic                      illegal;
  } dec_t;

  // Pure combinational decode of one request.
  function automatic dec_t decode(input logic [2:0] alu_op, input logic [5:0] funct);
    dec_t d;
    d.ctrl    = ALU_NOP;
    d.hilo_we = 1'b0;
    d.hilo_rd = HILO_RD_NONE;
    d.illegal = 1'b0;
    unique case (alu_op)
      ALUOP_ADD:  d.ctrl = ALU_ADD;
      ALUOP_SUB:  d.ctrl = ALU_SUB;
      ALUOP_AND:  d.ctrl = ALU_AND;
      ALUOP_OR:   d.ctrl = ALU_OR;
      ALUOP_XOR:  d.ctrl = ALU_XOR;
      ALUOP_SLT:  d.ctrl = ALU_SLT;
      ALUOP_SLTU: d.ctrl = ALU_SLTU;
      ALUOP_RTYPE: begin
        case (funct)
          // JR only needs the ALU to pass rs through, so it decodes as ADD.
          FUNCT_ADD, FUNCT_ADDU, FUNCT_JR: d.ctrl = ALU_ADD;
          FUNCT_SUB, FUNCT_SUBU:           d.ctrl = ALU_SUB;
          FUNCT_SLL, FUNCT_SLLV:           d.ctrl = ALU_SLL;
          FUNCT_SRL, FUNCT_SRLV:           d.ctrl = ALU_SRL;
          FUNCT_SRA, FUNCT_SRAV:           d.ctrl = ALU_SRA;
          FUNCT_AND:                       d.ctrl = ALU_AND;
          FUNCT_OR:                        d.ctrl = ALU_OR;
          FUNCT_XOR:                       d.ctrl = ALU_XOR;
          FUNCT_NOR:                       d.ctrl = ALU_NOR;
          FUNCT_SLT:                       d.ctrl = ALU_SLT;
          FUNCT_SLTU:                      d.ctrl = ALU_SLTU;
          FUNCT_MULT: begin
            d.ctrl    = ALU_MULT;
            d.hilo_we = 1'b1;
          end
          FUNCT_MULTU: begin
            d.ctrl    = ALU_MULTU;
            d.hilo_we = 1'b1;
          end
          FUNCT_DIV: begin
            d.ctrl    = ALU_DIV;
            d.hilo_we = 1'b1;
          end
          FUNCT_DIVU: begin
            d.ctrl    = ALU_DIVU;
            d.hilo_we = 1'b1;
          end
          FUNCT_MFHI: begin
            d.ctrl    = ALU_ADD;
            d.hilo_rd = HILO_RD_HI;
          end
          FUNCT_MFLO: begin
            d.ctrl    = ALU_ADD;
            d.hilo_rd = HILO_RD_LO;
          end
          default: d.illegal = 1'b1;
        endcase
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_control_mc_muldiv_busy_counter.sv
// HI/LO occupancy counter: loads the mul/div latency on start, counts down to
// zero, reports busy while nonzero and pulses done during the last busy cycle.
module alu_control_mc_muldiv_busy_counter #(
  parameter int unsigned Lat  = 32,
  parameter int unsigned CntW = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  output logic busy_o,
  output logic done_o
);

  logic [CntW-1:0] count_q, count_d;

  // Load has priority; the interlock upstream keeps load away from a busy count.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = CntW'(Lat);
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign busy_o = (count_q != '0);
  // Count of one means the next edge takes it to zero.
  assign done_o = (count_q == CntW'(1));

endmodule

// File: rtl/alu_control_mc.sv
// Registered, handshaked ALU control decoder for the multi-cycle MIPS datapath.
// Decodes alu_op/funct into an ALU op code plus HI/LO controls, one register
// stage of latency, and interlocks HI/LO users against an in-flight mul/div.
module alu_control_mc
  import alu_control_mc_pkg::*;
#(
  parameter int unsigned ALUOP_W    = 3,
  parameter int unsigned ALU_CTRL_W = 4,
  parameter int unsigned MULDIV_LAT = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALUOP_W-1:0]    alu_op,
  input  logic [5:0]            funct,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  hilo_we,
  output logic [1:0]            hilo_rd,
  output logic                  illegal,
  output logic                  muldiv_busy,
  output logic                  muldiv_done
);

  dec_t dec;
  dec_t res_q, res_d;
  logic out_valid_q, out_valid_d;
  logic hazard;
  logic accept;

  // Decode of the request currently presented upstream.
  always_comb begin
    dec = decode(alu_op[2:0], funct);
  end

  // Anything touching HI/LO must wait for the unit to drain.
  assign hazard   = muldiv_busy && (dec.hilo_we || (dec.hilo_rd != HILO_RD_NONE));
  assign in_ready = (!out_valid_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // Output-register next state: load on accept, drain on consume, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    res_d       = res_q;
    if (accept) begin
      out_valid_d = 1'b1;
      res_d       = dec;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
    end
  end

  alu_control_mc_muldiv_busy_counter #(
    .Lat  (MULDIV_LAT),
    .CntW (8)
  ) u_busy_counter (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (accept && dec.hilo_we),
    .busy_o (muldiv_busy),
    .done_o (muldiv_done)
  );

  assign out_valid   = out_valid_q;
  assign alu_control = ALU_CTRL_W'(res_q.ctrl);
  assign hilo_we     = res_q.hilo_we;
  assign hilo_rd     = res_q.hilo_rd;
  assign illegal     = res_q.illegal;

endmodule

// File: tb/tb_alu_control_mc.sv
// Self-checking bench for alu_control_mc: scoreboard queue fed by the driver,
// drained by an independent output monitor, plus a table-based reference model.
module tb_alu_control_mc;
  import alu_control_mc_pkg::*;

  localparam int unsigned Lat = 4;
  localparam logic [2:0] R = 3'b010;
  localparam logic [5:0] LEGAL_F [23] = '{
    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h10, 6'h12, 6'h18, 6'h19, 6'h1A,
    6'h1B, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

  typedef struct packed {
    logic [3:0] ctrl;
    logic       we;
    logic [1:0] rd;
    logic       ill;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (latency 4).
  logic       rst, in_valid, out_ready, in_ready, out_valid;
  logic       hilo_we, illegal, muldiv_busy, muldiv_done;
  logic [2:0] alu_op;
  logic [5:0] funct;
  logic [3:0] alu_control;
  logic [1:0] hilo_rd;

  // Second DUT (latency 1).
  logic       rst1, in_valid1, out_ready1, in_ready1, out_valid1;
  logic       hilo_we1, illegal1, muldiv_busy1, muldiv_done1;
  logic [2:0] alu_op1;
  logic [5:0] funct1;
  logic [3:0] alu_control1;
  logic [1:0] hilo_rd1;

  alu_control_mc #(.ALUOP_W(3), .ALU_CTRL_W(4), .MULDIV_LAT(Lat)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_op(alu_op),
    .funct(funct), .out_valid(out_valid), .out_ready(out_ready), .alu_control(alu_control),
    .hilo_we(hilo_we), .hilo_rd(hilo_rd), .illegal(illegal), .muldiv_busy(muldiv_busy),
    .muldiv_done(muldiv_done)
  );

  alu_control_mc #(.ALUOP_W(3), .ALU_CTRL_W(4), .MULDIV_LAT(1)) dut1 (
    .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1), .alu_op(alu_op1),
    .funct(funct1), .out_valid(out_valid1), .out_ready(out_ready1),
    .alu_control(alu_control1), .hilo_we(hilo_we1), .hilo_rd(hilo_rd1), .illegal(illegal1),
    .muldiv_busy(muldiv_busy1), .muldiv_done(muldiv_done1)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  exp_t rtab [64];
  exp_t otab [8];
  exp_t sb_q [$];

  // Reference model state: cycle number, busy window, output-valid flag.
  int   cyc = 0;
  int   bs  = 1;
  int   be  = 0;
  logic m_ov = 1'b0;
  logic last_acc = 1'b0;
  logic s_busy, s_done, s_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic exp_t mk(input logic [3:0] c, input logic we, input logic [1:0] rd,
                              input logic ill);
    exp_t e;
    e.ctrl = c;
    e.we   = we;
    e.rd   = rd;
    e.ill  = ill;
    return e;
  endfunction

  function automatic exp_t ref_dec(input logic [2:0] op, input logic [5:0] f);
    return (op == R) ? rtab[f] : otab[op];
  endfunction

  function automatic logic [5:0] pick_f();
    if ($urandom_range(0, 9) < 8) return LEGAL_F[$urandom_range(0, 22)];
    return 6'($urandom);
  endfunction

  // One clock: check handshake/busy against the model at negedge, advance at posedge.
  task automatic step();
    exp_t e;
    logic bsy, rdy;
    @(negedge clk);
    e   = ref_dec(alu_op, funct);
    bsy = (cyc >= bs) && (cyc <= be);
    rdy = (!m_ov || out_ready) && !(bsy && (e.we || (e.rd != 2'b00)));
    s_busy = muldiv_busy;
    s_done = muldiv_done;
    s_rdy  = in_ready;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("muldiv_busy", 32'(muldiv_busy), 32'(bsy));
    chk("muldiv_done", 32'(muldiv_done), 32'(bsy && (cyc == be)));
    last_acc = in_valid && rdy && !rst;
    if (last_acc) sb_q.push_back(e);
    @(posedge clk);
    if (rst) begin
      m_ov = 1'b0;
      bs   = 1;
      be   = 0;
      sb_q.delete();
    end else if (last_acc) begin
      m_ov = 1'b1;
      if (e.we) begin
        bs = cyc + 1;
        be = cyc + int'(Lat);
      end
    end else if (m_ov && out_ready) begin
      m_ov = 1'b0;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Present one request until accepted; n returns the number of cycles it took.
  task automatic send(input logic [2:0] op, input logic [5:0] f, output int n);
    n = 0;
    in_valid = 1'b1;
    alu_op   = op;
    funct    = f;
    do begin
      step();
      n++;
    end while (!last_acc && n < 100);
    if (!last_acc) chk("accept timeout", 32'(0), 32'(1));
    in_valid = 1'b0;
  endtask

  // Monitor: compare presented output with the scoreboard head, pop on consume.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("output with empty scoreboard", 32'(1), 32'(0));
        end else begin
          chk("res alu_control", 32'(alu_control), 32'(sb_q[0].ctrl));
          chk("res hilo_we", 32'(hilo_we), 32'(sb_q[0].we));
          chk("res hilo_rd", 32'(hilo_rd), 32'(sb_q[0].rd));
          chk("res illegal", 32'(illegal), 32'(sb_q[0].ill));
          if (out_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1);
  end

  initial begin
    int n, nb, nd, dpos, ns;
    int a0, a1, dones, busys;
    logic acc1;

    // Reference tables straight from the decode rules.
    for (int i = 0; i < 64; i++) rtab[i] = mk(ALU_NOP, 1'b0, 2'b00, 1'b1);
    rtab[6'h20] = mk(ALU_ADD, 0, 2'b00, 0);   rtab[6'h21] = mk(ALU_ADD, 0, 2'b00, 0);
    rtab[6'h08] = mk(ALU_ADD, 0, 2'b00, 0);   rtab[6'h22] = mk(ALU_SUB, 0, 2'b00, 0);
    rtab[6'h23] = mk(ALU_SUB, 0, 2'b00, 0);   rtab[6'h00] = mk(ALU_SLL, 0, 2'b00, 0);
    rtab[6'h04] = mk(ALU_SLL, 0, 2'b00, 0);   rtab[6'h02] = mk(ALU_SRL, 0, 2'b00, 0);
    rtab[6'h06] = mk(ALU_SRL, 0, 2'b00, 0);   rtab[6'h03] = mk(ALU_SRA, 0, 2'b00, 0);
    rtab[6'h07] = mk(ALU_SRA, 0, 2'b00, 0);   rtab[6'h24] = mk(ALU_AND, 0, 2'b00, 0);
    rtab[6'h25] = mk(ALU_OR, 0, 2'b00, 0);    rtab[6'h26] = mk(ALU_XOR, 0, 2'b00, 0);
    rtab[6'h27] = mk(ALU_NOR, 0, 2'b00, 0);   rtab[6'h2A] = mk(ALU_SLT, 0, 2'b00, 0);
    rtab[6'h2B] = mk(ALU_SLTU, 0, 2'b00, 0);  rtab[6'h18] = mk(ALU_MULT, 1, 2'b00, 0);
    rtab[6'h19] = mk(ALU_MULTU, 1, 2'b00, 0); rtab[6'h1A] = mk(ALU_DIV, 1, 2'b00, 0);
    rtab[6'h1B] = mk(ALU_DIVU, 1, 2'b00, 0);  rtab[6'h10] = mk(ALU_ADD, 0, 2'b10, 0);
    rtab[6'h12] = mk(ALU_ADD, 0, 2'b01, 0);
    otab[0] = mk(ALU_ADD, 0, 2'b00, 0);  otab[1] = mk(ALU_SUB, 0, 2'b00, 0);
    otab[2] = mk(ALU_NOP, 0, 2'b00, 1);  otab[3] = mk(ALU_AND, 0, 2'b00, 0);
    otab[4] = mk(ALU_OR, 0, 2'b00, 0);   otab[5] = mk(ALU_XOR, 0, 2'b00, 0);
    otab[6] = mk(ALU_SLT, 0, 2'b00, 0);  otab[7] = mk(ALU_SLTU, 0, 2'b00, 0);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; alu_op = 3'b000; funct = 6'h00;
    rst1 = 1'b1; in_valid1 = 1'b0; out_ready1 = 1'b1; alu_op1 = 3'b000; funct1 = 6'h00;
    @(posedge clk);
    #1;

    // Reset state.
    idle(3);
    rst = 1'b0;
    rst1 = 1'b0;
    chk("reset alu_control", 32'(alu_control), 32'(0));
    chk("reset hilo_we", 32'(hilo_we), 32'(0));
    chk("reset hilo_rd", 32'(hilo_rd), 32'(0));
    chk("reset illegal", 32'(illegal), 32'(0));

    // Sweep every class and every supported funct, plus an illegal one.
    for (int op = 0; op < 8; op++) begin
      if (op != 2) send(3'(op), pick_f(), n);
    end
    for (int i = 0; i < 23; i++) send(R, LEGAL_F[i], n);
    send(R, 6'h3F, n);
    chk("illegal accept latency", 32'(n), 32'(1));
    idle(Lat + 2);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        alu_op   = 3'($urandom_range(0, 7));
        funct    = pick_f();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(Lat + 3);

    // Backpressure: hold a result 10 cycles, then a queued ADD goes the same cycle.
    out_ready = 1'b0;
    send(3'b000, 6'h00, n);
    in_valid = 1'b1;
    alu_op = 3'b000;
    for (int i = 0; i < 10; i++) step();
    out_ready = 1'b1;
    step();
    chk("bp dut in_ready on release", 32'(s_rdy), 32'(1));
    in_valid = 1'b0;
    idle(2);

    // DIV then MFHI held: stalls exactly for the busy window.
    send(R, 6'h1A, n);
    in_valid = 1'b1; alu_op = R; funct = 6'h10;
    nb = 0; nd = 0; dpos = -1; ns = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_busy) nb++;
      if (s_done) begin
        nd++;
        dpos = nb;
      end
      if (!s_rdy) ns++;
      if (last_acc) break;
    end
    in_valid = 1'b0;
    chk("div busy cycles", 32'(nb), 32'(Lat));
    chk("div done pulses", 32'(nd), 32'(1));
    chk("div done position", 32'(dpos), 32'(Lat));
    chk("mfhi stall cycles", 32'(ns), 32'(Lat));
    chk("mfhi hilo_rd", 32'(hilo_rd), 32'(2'b10));

    // Non-HI/LO ops go through while busy; MFLO waits.
    send(R, 6'h1A, n);
    send(R, 6'h25, n);
    chk("or while busy latency", 32'(n), 32'(1));
    send(3'b100, 6'h1A, n);
    send(R, 6'h12, n);
    idle(2);

    // Reset in the middle of a busy window.
    send(R, 6'h18, n);
    idle(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst mid-busy muldiv_busy", 32'(muldiv_busy), 32'(0));
    chk("rst mid-busy out_valid", 32'(out_valid), 32'(0));
    send(R, 6'h12, n);
    chk("mflo after rst latency", 32'(n), 32'(1));
    idle(2);

    // Latency 1: MULT then MULTU held valid.
    in_valid1 = 1'b1; alu_op1 = R; funct1 = 6'h18;
    a0 = -1; a1 = -1; dones = 0; busys = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (muldiv_done1) dones++;
      if (muldiv_busy1) busys++;
      acc1 = in_valid1 && in_ready1;
      @(posedge clk);
      #1;
      if (acc1 && a0 < 0) begin
        a0 = k;
        funct1 = 6'h19;
        chk("lat1 mult alu_control", 32'(alu_control1), 32'(ALU_MULT));
        chk("lat1 mult hilo_we", 32'(hilo_we1), 32'(1));
        chk("lat1 mult hilo_rd", 32'(hilo_rd1), 32'(0));
        chk("lat1 mult illegal", 32'(illegal1), 32'(0));
      end else if (acc1 && a1 < 0) begin
        a1 = k;
        in_valid1 = 1'b0;
        chk("lat1 multu alu_control", 32'(alu_control1), 32'(ALU_MULTU));
        chk("lat1 multu out_valid", 32'(out_valid1), 32'(1));
      end
    end
    chk("lat1 accept spacing", 32'(a1 - a0), 32'(2));
    chk("lat1 done pulses", 32'(dones), 32'(2));
    chk("lat1 busy cycles", 32'(busys), 32'(2));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
